noc_sw_alloc: RTL and testbench

NOC_SW_ALLOC -- requirements
Module: noc_sw_alloc

---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_rr_arb.sv | 27 ++
 rtl/noc_sw_alloc.sv | 135 +++++++++++++
 tb/tb_noc_sw_alloc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC switch allocator.
package noc_pkg;

  localparam int PORT_NUM = 5;
  localparam int SEL_W    = 3;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Cyclic successor of a port index, used to move the round-robin pointer past a winner.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping around.
module noc_rr_arb #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         gnt_valid,
  output logic [2:0]   gnt_idx
);

  int cand;

  // Scan from farthest to nearest so the candidate closest to ptr is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 3'(cand);
      end
    end
  end

endmodule

// File: rtl/noc_sw_alloc.sv
// Per-output switch allocator with packet locking and credit flow control.
// Define NOC_SW_ALLOC_ERR_EN to add the sticky err_o protocol-error flag.
module noc_sw_alloc
  import noc_pkg::*;
#(
  parameter int PORT_NUM   = noc_pkg::PORT_NUM,
  parameter int CREDIT_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_NUM-1:0]   in_valid_i,
  input  logic [PORT_NUM*3-1:0] in_out_sel_i,
  input  logic [PORT_NUM-1:0]   in_tail_i,
  output logic [PORT_NUM-1:0]   in_ready_o,
  input  logic [PORT_NUM-1:0]   credit_i,
  output logic [PORT_NUM-1:0]   out_valid_o,
  output logic [PORT_NUM*3-1:0] out_in_sel_o
`ifdef NOC_SW_ALLOC_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int CW = $clog2(CREDIT_NUM + 1);

  logic [PORT_NUM-1:0]   gnt_vec;
  logic [PORT_NUM*3-1:0] gnt_idx_flat;
`ifdef NOC_SW_ALLOC_ERR_EN
  logic [PORT_NUM-1:0]   err_hit;
`endif

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    alloc_state_e  state_q;
    logic [2:0]    owner_q;
    logic [2:0]    ptr_q;
    logic [CW-1:0] credit_q;

    logic [PORT_NUM-1:0] req;
    logic                arb_valid;
    logic [2:0]          arb_idx;
    logic                gnt;
    logic [2:0]          gnt_idx;
    logic                gnt_tail;

    // Out-of-range selects never match any o, so they are never granted.
    always_comb begin
      req = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        req[i] = in_valid_i[i] && (in_out_sel_i[i*3 +: 3] == 3'(o));
      end
    end

    noc_rr_arb #(.N(PORT_NUM)) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
    );

    always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      if (!rst && (credit_q != '0)) begin
        if (state_q == IDLE) begin
          gnt     = arb_valid;
          gnt_idx = arb_idx;
        end else if (req[owner_q]) begin
          gnt     = 1'b1;
          gnt_idx = owner_q;
        end
      end
    end

    assign gnt_tail                = in_tail_i[gnt_idx];
    assign gnt_vec[o]              = gnt;
    assign gnt_idx_flat[o*3 +: 3]  = gnt_idx;
    assign out_valid_o[o]          = gnt;
    assign out_in_sel_o[o*3 +: 3]  = gnt_idx;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        owner_q  <= '0;
        ptr_q    <= '0;
        credit_q <= CW'(CREDIT_NUM);
      end else begin
        if (gnt) begin
          if (state_q == IDLE) begin
            if (gnt_tail) begin
              ptr_q <= next_idx(gnt_idx, PORT_NUM);
            end else begin
              state_q <= LOCKED;
              owner_q <= gnt_idx;
            end
          end else if (gnt_tail) begin
            state_q <= IDLE;
            ptr_q   <= next_idx(owner_q, PORT_NUM);
          end
        end
        // A returned credit with no transfer at full count is dropped (saturation).
        case ({gnt, credit_i[o]})
          2'b10:   credit_q <= credit_q - 1'b1;
          2'b01:   if (credit_q != CW'(CREDIT_NUM)) credit_q <= credit_q + 1'b1;
          default: credit_q <= credit_q;
        endcase
      end
    end

`ifdef NOC_SW_ALLOC_ERR_EN
    assign err_hit[o] = (credit_i[o] && !gnt && (credit_q == CW'(CREDIT_NUM))) ||
                        ((state_q == LOCKED) && in_valid_i[owner_q] &&
                         (in_out_sel_i[owner_q*3 +: 3] != 3'(o)));
`endif
  end

  always_comb begin
    in_ready_o = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (gnt_vec[o] && (gnt_idx_flat[o*3 +: 3] == 3'(i))) in_ready_o[i] = 1'b1;
      end
    end
  end

`ifdef NOC_SW_ALLOC_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (|err_hit) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_sw_alloc.sv
// Directed-vector scoreboard bench for noc_sw_alloc; checks err_o when NOC_SW_ALLOC_ERR_EN is defined.
module tb_noc_sw_alloc;

  logic        clk;
  logic        rst;
  logic [4:0]  in_valid_i;
  logic [14:0] in_out_sel_i;
  logic [4:0]  in_tail_i;
  logic [4:0]  in_ready_o;
  logic [4:0]  credit_i;
  logic [4:0]  out_valid_o;
  logic [14:0] out_in_sel_o;
`ifdef NOC_SW_ALLOC_ERR_EN
  logic        err_o;
`endif

  typedef struct {
    logic [4:0]  valid;
    logic [14:0] sel;
    logic [4:0]  ready;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sticky_err = 1'b0;
  bit   drv_done = 1'b0;

  noc_sw_alloc #(.PORT_NUM(5), .CREDIT_NUM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_out_sel_i (in_out_sel_i),
    .in_tail_i    (in_tail_i),
    .in_ready_o   (in_ready_o),
    .credit_i     (credit_i),
    .out_valid_o  (out_valid_o),
    .out_in_sel_o (out_in_sel_o)
`ifdef NOC_SW_ALLOC_ERR_EN
    ,
    .err_o        (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] sels(int a, int b, int c, int d, int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Drive one cycle just after the rising edge and queue what the outputs must show in it.
  task automatic applyStimulus(input logic r, input logic [4:0] v, input logic [14:0] s,
                               input logic [4:0] t, input logic [4:0] c,
                               input logic [4:0] ev, input logic [14:0] es,
                               input logic [4:0] er, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    in_valid_i   = v;
    in_out_sel_i = s;
    in_tail_i    = t;
    credit_i     = c;
    e.valid = ev;
    e.sel   = es;
    e.ready = er;
    e.err   = sticky_err;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    if (out_valid_o !== e.valid) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %b want %b", e.name, out_valid_o, e.valid);
    end
    checks++;
    if (out_in_sel_o !== e.sel) begin
      errors++;
      $display("[TB] FAIL %s out_in_sel: got %h want %h", e.name, out_in_sel_o, e.sel);
    end
    checks++;
    if (in_ready_o !== e.ready) begin
      errors++;
      $display("[TB] FAIL %s in_ready: got %b want %b", e.name, in_ready_o, e.ready);
    end
`ifdef NOC_SW_ALLOC_ERR_EN
    checks++;
    if (err_o !== e.err) begin
      errors++;
      $display("[TB] FAIL %s err_o: got %b want %b", e.name, err_o, e.err);
    end
`endif
  endtask

  // Monitor: compares on the falling edge, away from the state-update edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput();
    end
  end

  initial begin
    rst          = 1'b1;
    in_valid_i   = '0;
    in_out_sel_i = '0;
    in_tail_i    = '0;
    credit_i     = '0;

    applyStimulus(1, 5'b00001, sels(1,0,0,0,0), 5'b00001, 0, 0, 0, 0, "in_reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");
    applyStimulus(0, 5'b10100, sels(0,0,5,0,7), 5'b11111, 0, 0, 0, 0, "sel_out_of_range");

    $display("[TB] credit exhaustion on output 1");
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 5'b00001, sels(1,0,0,0,0), 5'b00001, 0, 5'b00010, 0, 5'b00001, "o1_stream");
    applyStimulus(0, 5'b00001, sels(1,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o1_no_credit");
    applyStimulus(0, 5'b00001, sels(1,0,0,0,0), 5'b00001, 5'b00010, 0, 0, 0, "o1_credit_same_cycle");
    applyStimulus(0, 5'b00001, sels(1,0,0,0,0), 5'b00001, 0, 5'b00010, 0, 5'b00001, "o1_credit_used");
    applyStimulus(0, 5'b00001, sels(1,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o1_empty_again");
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 0, 0, 5'b00010, 0, 0, 0, "o1_refill");

    $display("[TB] round robin on output 4");
    for (int k = 0; k < 6; k++)
      applyStimulus(0, 5'b00111, sels(4,4,4,0,0), 5'b00111, 5'b10000,
                    5'b10000, sels(0,0,0,0,k % 3), 5'(1 << (k % 3)), "o4_rr");

    $display("[TB] packet lock on output 2");
    applyStimulus(0, 5'b01010, sels(0,2,0,2,0), 5'b01000, 5'b00100, 5'b00100, sels(0,0,1,0,0), 5'b00010, "o2_head");
    applyStimulus(0, 5'b01010, sels(0,2,0,2,0), 5'b01000, 5'b00100, 5'b00100, sels(0,0,1,0,0), 5'b00010, "o2_body");
    applyStimulus(0, 5'b01010, sels(0,2,0,2,0), 5'b01010, 5'b00100, 5'b00100, sels(0,0,1,0,0), 5'b00010, "o2_tail");
    applyStimulus(0, 5'b01000, sels(0,2,0,2,0), 5'b01000, 5'b00100, 5'b00100, sels(0,0,3,0,0), 5'b01000, "o2_next_owner");

    $display("[TB] credit hold and saturation on output 3");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 5'b01000, 0, 5'b00001, "o3_c4");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 5'b01000, 0, 5'b00001, "o3_c3");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 5'b01000, 5'b01000, 0, 5'b00001, "o3_c2_hold");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 5'b01000, 0, 5'b00001, "o3_c2");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 5'b01000, 0, 5'b00001, "o3_c1");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o3_c0");
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 0, 0, 5'b01000, 0, 0, 0, "o3_refill");
    applyStimulus(0, 0, 0, 0, 5'b01000, 0, 0, 0, "o3_overflow");
    sticky_err = 1'b1;
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 5'b01000, 0, 5'b00001, "o3_saturated_stream");
    applyStimulus(0, 5'b00001, sels(3,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o3_saturated_empty");

    $display("[TB] reset mid-packet on output 0");
    applyStimulus(0, 5'b01000, sels(0,0,0,0,0), 5'b00000, 0, 5'b00001, sels(3,0,0,0,0), 5'b01000, "o0_lock_owner3");
    applyStimulus(0, 5'b00001, sels(0,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o0_locked_ignores_in0");
    sticky_err = 1'b0;
    applyStimulus(1, 5'b01001, sels(0,0,0,0,0), 5'b00001, 0, 0, 0, 0, "o0_reset_midpacket");
    applyStimulus(0, 5'b00001, sels(0,0,0,0,0), 5'b00001, 0, 5'b00001, 0, 5'b00001, "o0_after_reset");

    @(posedge clk);
    #1;
    in_valid_i = '0;
    credit_i   = '0;
    drv_done   = 1'b1;
  end

  // Bounded drain of the scoreboard, then the summary line.
  initial begin
    int waited;
    waited = 0;
    while (!(drv_done && exp_q.size() == 0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0 || !drv_done) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
